branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 112 +++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: tracks in-flight predictions in a FIFO, checks each
// resolved instruction against its predicted next-PC, trains the predictor and redirects fetch.
module branch_resolve #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fe_valid,
    input  logic [31:0] fe_pc,
    input  logic [31:0] fe_pred_pc,
    output logic        fe_ready,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic [4:0]  occupancy,
    output logic [15:0] br_cnt,
    output logic [15:0] miss_cnt,
    output logic        underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, REDIR} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [4:0]              count;
    logic [DEPTH-1:0][31:0]  q_pc, q_pred;
    logic                    push, resolve, mispredict;
    logic [31:0]             head_pc, head_pred, actual_pc;

    assign head_pc    = q_pc[rd_ptr];
    assign head_pred  = q_pred[rd_ptr];
    assign fe_ready   = (state == RUN) && (count < 5'(DEPTH));
    assign push       = fe_valid && fe_ready;
    assign resolve    = ex_valid && (state == RUN) && (count != 5'd0);
    assign actual_pc  = (ex_is_br && ex_taken) ? ex_target : head_pc + 32'd4;
    // Every resolved instruction is checked, branch or not.
    assign mispredict = resolve && (actual_pc != head_pred);
    assign occupancy  = count;
    assign redir_valid = (state == REDIR);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispredict) state_nxt = REDIR;
            REDIR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // A mispredict flushes the queue and drops any same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (resolve) rd_ptr <= rd_ptr + PW'(1);
            count <= count + 5'(push) - 5'(resolve);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= fe_pc;
            q_pred[wr_ptr] <= fe_pred_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid  <= 1'b0;
            upd_pc     <= '0;
            upd_target <= '0;
            upd_taken  <= 1'b0;
            redir_pc   <= '0;
            br_cnt     <= '0;
            miss_cnt   <= '0;
            underflow  <= 1'b0;
        end else begin
            upd_valid <= resolve && ex_is_br;
            if (resolve && ex_is_br) begin
                upd_pc     <= head_pc;
                upd_target <= ex_target;
                upd_taken  <= ex_taken;
                if (br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
            end
            if (mispredict) begin
                redir_pc <= actual_pc;
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
            if (ex_valid && (state == RUN) && (count == 5'd0)) underflow <= 1'b1;
        end
    end
endmodule
